ram_access_master: RTL
======================

# ram_access_master

Initiator for the `ram_controller` port. It accepts one command at a time on a valid/ready command channel and drives the controller's `read_en`/`write_en`/`addr`/`write_data` under the `ready` handshake. For reads, it captures `read_data` after a fixed latency. Every command produces exactly one response on a valid/ready response channel: a write ack, read data, or a timeout error. It sits between a CPU/DMA-side requester and `ram_controller`.

## Interface
- `ADDR_WIDTH`, 8, address width; matches the controller.
- `DATA_WIDTH`, 32, data width; matches the controller.
- `READ_LATENCY`, 2, edges from the read transfer edge to the `mem_read_data` sampling edge; must be ≥1.
- `TIMEOUT_CYCLES`, 16, consecutive stalled cycles before the block gives up; 0 disables the timeout.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  target address.
- `cmd_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_write`  out  1  response belongs to a write.
- `rsp_err`  out  1  timeout occurred; no memory access completed.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and errors.
- `mem_read_en`  out  1  to controller `read_en`.
- `mem_write_en`  out  1  to controller `write_en`.
- `mem_addr`  out  ADDR_WIDTH  to controller `addr`.
- `mem_write_data`  out  DATA_WIDTH  to controller `write_data`.
- `mem_read_data`  in  DATA_WIDTH  from controller `read_data`.
- `mem_ready`  in  1  from controller `ready`.

## Operation
- All outputs are registered.
- Reset value of every output is 0, including `cmd_ready`.
- `cmd_ready` rises at the first edge after `reset_n` deasserts.
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - A command is accepted at an edge where `cmd_valid` & `cmd_ready` are both 1.
  - On accept: latch addr/wdata/write; drive `mem_addr`, `mem_write_data`, and `mem_write_en` or `mem_read_en`; clear `cmd_ready`; go to ISSUE.
  - `mem_write_data` is 0 for reads.
- **ISSUE**
  - The enable is held, with addr/data stable, until the transfer edge: the edge where the enable and `mem_ready` are both 1.
  - At the transfer edge, the enable drops.
  - Write → RESP with `rsp_write`=1, `rsp_rdata`=0.
  - Read → RD_WAIT.
  - Stall counter: increments each cycle in ISSUE with `mem_ready`=0, and clears when `mem_ready`=1.
  - On reaching `TIMEOUT_CYCLES` (if nonzero): drop the enable and go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
- **RD_WAIT**
  - The latency counter counts edges.
  - At transfer edge + `READ_LATENCY`, capture `mem_read_data` into `rsp_rdata` and go to RESP.
  - `mem_ready` is ignored in this state.
- **RESP**
  - `rsp_valid`=1, with all `rsp_*` fields held stable until `rsp_ready`=1 at an edge.
  - On that edge: clear `rsp_valid` and the `rsp_*` fields, set `cmd_ready`=1, go to IDLE.
- Exactly one transaction is outstanding at a time. The enables are mutually exclusive and never both 1.

## Timing
- Write: accept edge A → enable high from A.
  - If `mem_ready`=1 continuously, the transfer occurs at A+1 and `rsp_valid`=1 after A+2.
- Read (`READ_LATENCY`=2): transfer edge T → data sampled at T+2 → `rsp_valid` visible after T+2.
- Minimum command-to-command spacing: write = 4 edges, read = 5 edges (with `rsp_ready` held at 1).
- `mem_ready` low at the edge after accept: the enable stays asserted; no deassert/reassert glitch.
- `mem_ready` toggling without a full stall of `TIMEOUT_CYCLES` cycles: the counter restarts; no error.
- `cmd_valid` asserted while not in IDLE: ignored; the command must be held by the source.
- Async reset mid-transaction:
  - Enables and `rsp_valid` drop immediately.
  - The in-flight command is lost and produces no response.
  - FSM returns to IDLE; `cmd_ready` returns at the first edge after release.

## Structure
- Package `ram_master_pkg` holds:
  - the FSM state enum `ram_master_state_t`;
  - the response struct `ram_rsp_t` (write, err, rdata);
  - localparams for counter widths (`$clog2(TIMEOUT_CYCLES+1)`, `$clog2(READ_LATENCY+1)`).
- One sub-module, `ram_stall_timer`: a loadable stall/latency down-counter with a `done` flag. It is instantiated twice, once for the timeout and once for read latency.

## Test plan
- Reset with `reset_n`=0 for 20 ns, `mem_ready`=1 → all outputs 0 during reset; `cmd_ready`=1 one edge after release.
- Write 0x10 ← 0xDEADBEAC, then read 0x10 against a behavioural `ram_controller` model → `mem_write_en` high exactly 1 cycle; read response `rsp_rdata`=0xDEADBEAC, `rsp_err`=0.
- Hold `mem_ready`=0 for 5 cycles during a read of 0x20 (stored 0x12345678) → `mem_read_en` held 6 cycles with `mem_addr`=0x20 stable; response 0x12345678.
- `mem_ready` stuck at 0, write to 0x30 → after 16 stalled cycles the enable drops; `rsp_err`=1, `rsp_write`=1, `rsp_rdata`=0.
- Keep `rsp_ready`=0 for 10 cycles after a read response of 0xABCDEF00 → `rsp_valid` and the data stable for all 10 cycles; `cmd_ready`=0 throughout; a new `cmd_valid` is not accepted.
- Assert `reset_n`=0 in RD_WAIT → `rsp_valid` never rises for that read; the next write/read pair (0x10 ← 0xCAFEBABE) completes correctly.

Source files
------------

// File: rtl/ram_access_master_pkg.sv
// ram_master_pkg: shared types and sizing for ram_access_master.
//   ram_master_state_t : command FSM states
//   ram_rsp_t          : response payload (write, err, rdata)
//   cnt_w()            : counter width able to hold 0..n, at least 1 bit
package ram_master_pkg;

   localparam int RAM_ADDR_W       = 8;
   localparam int RAM_DATA_W       = 32;
   localparam int RAM_READ_LAT_DEF = 2;
   localparam int RAM_TIMEOUT_DEF  = 16;

   localparam int RAM_TO_CNT_W  = $clog2(RAM_TIMEOUT_DEF + 1);
   localparam int RAM_LAT_CNT_W = $clog2(RAM_READ_LAT_DEF + 1);

   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2,
      RESP    = 2'd3
   } ram_master_state_t;

   // rdata is sized by RAM_DATA_W, so the master's DATA_WIDTH must match it.
   typedef struct packed {
      logic                  write;
      logic                  err;
      logic [RAM_DATA_W-1:0] rdata;
   } ram_rsp_t;

endpackage

// File: rtl/ram_access_master_if.sv
// ram_access_master_if: command, response and controller-side signals of the
// RAM access master.
//   master : view of ram_access_master (drives cmd_ready, rsp_*, mem_* requests)
//   slave  : view of the environment (requester, consumer and ram_controller)
interface ram_access_master_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_write;
   logic                  rsp_err;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   logic                  mem_read_en;
   logic                  mem_write_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_write_data;
   logic [DATA_WIDTH-1:0] mem_read_data;
   logic                  mem_ready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             mem_read_data, mem_ready,
      output cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata,
             mem_read_en, mem_write_en, mem_addr, mem_write_data
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             mem_read_data, mem_ready,
      input  cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata,
             mem_read_en, mem_write_en, mem_addr, mem_write_data
   );
endinterface

// File: rtl/ram_access_master_stall_timer.sv
// ram_stall_timer: loadable down-counter with a zero flag.
//   load/load_val : (re)start the count
//   dec           : count down one step, saturating at zero
//   done          : count is zero
import ram_master_pkg::*;

module ram_stall_timer #(
   parameter int W = RAM_TO_CNT_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/ram_access_master.sv
// ram_access_master: single-outstanding initiator for a ram_controller port.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus.cmd_*    : valid/ready command channel (write flag, addr, wdata)
//   bus.rsp_*    : valid/ready response channel (write ack, read data, timeout)
//   bus.mem_*    : controller side (read_en/write_en/addr/write_data, read_data, ready)
// All outputs come straight from flops.
import ram_master_pkg::*;

module ram_access_master #(
   parameter int ADDR_WIDTH     = RAM_ADDR_W,
   parameter int DATA_WIDTH     = RAM_DATA_W,
   parameter int READ_LATENCY   = RAM_READ_LAT_DEF,
   parameter int TIMEOUT_CYCLES = RAM_TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   ram_access_master_if.master bus
);

   localparam int TO_W  = cnt_w(TIMEOUT_CYCLES);
   localparam int LAT_W = cnt_w(READ_LATENCY);
   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

   // The timer flags done after load_val further steps, so loading N-1 makes
   // the Nth stalled cycle (or the Nth edge after the transfer) the trigger.
   localparam logic [TO_W-1:0]  TO_LOAD  = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

   ram_master_state_t     state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  rd_en_q, rd_en_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   ram_rsp_t              rsp_q, rsp_d;

   logic to_load, to_dec, to_done;
   logic lat_load, lat_dec, lat_done;

   ram_stall_timer #(.W(TO_W)) u_timeout (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (to_load),
      .load_val (TO_LOAD),
      .dec      (to_dec),
      .done     (to_done)
   );

   ram_stall_timer #(.W(LAT_W)) u_latency (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (lat_load),
      .load_val (LAT_LOAD),
      .dec      (lat_dec),
      .done     (lat_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rd_en_q     <= rd_en_d;
         wr_en_q     <= wr_en_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      rd_en_d     = rd_en_q;
      wr_en_d     = wr_en_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_d       = rsp_q;
      to_load     = 1'b0;
      to_dec      = 1'b0;
      lat_load    = 1'b0;
      lat_dec     = 1'b0;

      case (state_q)
         IDLE: begin
            // cmd_ready is low only right after reset; raise it first.
            if (!cmd_ready_q) begin
               cmd_ready_d = 1'b1;
            end else if (bus.cmd_valid) begin
               cmd_ready_d = 1'b0;
               addr_d      = bus.cmd_addr;
               wdata_d     = bus.cmd_write ? bus.cmd_wdata : '0;
               wr_en_d     = bus.cmd_write;
               rd_en_d     = !bus.cmd_write;
               to_load     = 1'b1;
               state_d     = ISSUE;
            end
         end

         ISSUE: begin
            // The enable that is high identifies the command type here.
            if (bus.mem_ready) begin
               wr_en_d = 1'b0;
               rd_en_d = 1'b0;
               to_load = 1'b1;
               if (wr_en_q) begin
                  rsp_d   = '{write: 1'b1, err: 1'b0, rdata: '0};
                  state_d = RESP;
               end else begin
                  lat_load = 1'b1;
                  state_d  = RD_WAIT;
               end
            end else if (TO_EN && to_done) begin
               wr_en_d = 1'b0;
               rd_en_d = 1'b0;
               rsp_d   = '{write: wr_en_q, err: 1'b1, rdata: '0};
               state_d = RESP;
            end else begin
               to_dec = 1'b1;
            end
         end

         RD_WAIT: begin
            // Read data is valid exactly on the sampling edge, so the
            // response is raised together with the capture.
            if (lat_done) begin
               rsp_d       = '{write: 1'b0, err: 1'b0, rdata: bus.mem_read_data};
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               lat_dec = 1'b1;
            end
         end

         RESP: begin
            // Write ack and timeout enter with rsp_valid low and raise it here.
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
            end else if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_d       = '0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.cmd_ready      = cmd_ready_q;
   assign bus.mem_read_en    = rd_en_q;
   assign bus.mem_write_en   = wr_en_q;
   assign bus.mem_addr       = addr_q;
   assign bus.mem_write_data = wdata_q;
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_write      = rsp_q.write;
   assign bus.rsp_err        = rsp_q.err;
   assign bus.rsp_rdata      = rsp_q.rdata;

endmodule
